// File: rtl/flatten_fc_controller.sv
// ---------------------------------------------------------------------------
// flatten_fc_controller
//
// Sequences the fully-connected layer that consumes the flattened feature
// vector held by the flatten buffer. When the buffer reports full, every
// output neuron is processed in turn. For each neuron the controller:
//   - streams all vector indices and matching weight addresses,
//   - accumulates the signed products in one shared MAC,
//   - adds the neuron bias, saturates, and emits one result.
// After the last neuron it pulses a clear to the flatten buffer.
//
// Ports:
//   clk             single clock, all state on rising edge
//   rst             synchronous active-high reset
//   i_buffer_full   flatten buffer holds a complete vector
//   o_vec_idx       vector element index (drives external element mux)
//   i_vec_data      signed element, valid one cycle after o_vec_idx
//   o_weight_addr   weight ROM address = neuron*IN_LEN + idx
//   i_weight        signed weight, valid one cycle after o_weight_addr
//   o_bias_addr     bias ROM address = current neuron
//   i_bias          signed bias for the current neuron
//   o_result_valid  one-cycle pulse, o_result/o_neuron_idx valid
//   o_result        saturated neuron output
//   o_neuron_idx    neuron index tagged with o_result
//   o_busy          high whenever the FSM is not idle
//   o_done          one-cycle pulse, frame complete
//   o_buffer_clear  one-cycle pulse to clear the flatten buffer
// ---------------------------------------------------------------------------
module flatten_fc_controller #(
  parameter int IN_LEN  = 225,
  parameter int NUM_OUT = 10,
  parameter int DATA_W  = 22,
  parameter int W_W     = 8,
  parameter int BIAS_W  = 32,
  parameter int ACC_W   = 38,
  parameter int OUT_W   = 32,
  parameter int ADDR_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_buffer_full,
  output logic [7:0]               o_vec_idx,
  input  logic signed [DATA_W-1:0] i_vec_data,
  output logic [ADDR_W-1:0]        o_weight_addr,
  input  logic signed [W_W-1:0]    i_weight,
  output logic [3:0]               o_bias_addr,
  input  logic signed [BIAS_W-1:0] i_bias,
  output logic                     o_result_valid,
  output logic signed [OUT_W-1:0]  o_result,
  output logic [3:0]               o_neuron_idx,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_buffer_clear
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int PROD_W = DATA_W + W_W;
  // One extra bit over the accumulator so acc + bias can never wrap.
  localparam int SUM_W  = ACC_W + 1;

  localparam logic [7:0] LAST_IDX    = 8'(IN_LEN - 1);
  localparam logic [3:0] LAST_NEURON = 4'(NUM_OUT - 1);

  logic [2:0]               state;
  logic [3:0]               neuron;
  logic                     pipe_valid;
  logic signed [ACC_W-1:0]  acc;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [SUM_W-1:0]  sum;
  logic signed [OUT_W-1:0]  sat;

  // Signed product of the returning element and weight, widened to the accumulator.
  always_comb begin
    prod     = $signed({{W_W{i_vec_data[DATA_W-1]}}, i_vec_data})
             * $signed({{DATA_W{i_weight[W_W-1]}}, i_weight});
    prod_ext = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
  end

  // Bias addition and clamp to the signed output range.
  always_comb begin
    sum = $signed({acc[ACC_W-1], acc})
        + $signed({{(SUM_W-BIAS_W){i_bias[BIAS_W-1]}}, i_bias});
    // The sum fits when all bits from the output sign bit upward agree.
    if ((&sum[SUM_W-1:OUT_W-1]) || !(|sum[SUM_W-1:OUT_W-1])) begin
      sat = sum[OUT_W-1:0];
    end else if (sum[SUM_W-1]) begin
      sat = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  // Control FSM, MAC accumulator and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      neuron         <= 4'd0;
      pipe_valid     <= 1'b0;
      acc            <= '0;
      o_vec_idx      <= 8'd0;
      o_weight_addr  <= '0;
      o_bias_addr    <= 4'd0;
      o_result_valid <= 1'b0;
      o_result       <= '0;
      o_neuron_idx   <= 4'd0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_buffer_clear <= 1'b0;
    end else begin
      o_result_valid <= 1'b0;
      o_done         <= 1'b0;
      o_buffer_clear <= 1'b0;
      // Data presented during a RUN cycle returns in the following cycle.
      pipe_valid     <= (state == S_RUN);
      if (pipe_valid) begin
        acc <= acc + prod_ext;
      end

      case (state)
        S_IDLE: begin
          if (i_buffer_full) begin
            state         <= S_RUN;
            neuron        <= 4'd0;
            acc           <= '0;
            o_vec_idx     <= 8'd0;
            o_weight_addr <= '0;
            o_bias_addr   <= 4'd0;
            o_busy        <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          if (o_vec_idx == LAST_IDX) begin
            state <= S_DRAIN;
          end else begin
            o_vec_idx     <= o_vec_idx + 8'd1;
            o_weight_addr <= o_weight_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end

        S_DRAIN: begin
          state <= S_WRITE;
        end

        S_WRITE: begin
          o_result       <= sat;
          o_neuron_idx   <= neuron;
          o_result_valid <= 1'b1;
          if (neuron == LAST_NEURON) begin
            state          <= S_DONE;
            o_done         <= 1'b1;
            o_buffer_clear <= 1'b1;
          end else begin
            state         <= S_RUN;
            neuron        <= neuron + 4'd1;
            o_bias_addr   <= neuron + 4'd1;
            acc           <= '0;
            o_vec_idx     <= 8'd0;
            // Weight rows are contiguous, so the next neuron starts one past the last address.
            o_weight_addr <= o_weight_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flatten_fc_controller.sv
// ---------------------------------------------------------------------------
// tb_flatten_fc_controller
//
// Self-checking bench for flatten_fc_controller with default parameters.
// External vector mux, weight ROM and bias ROM are modelled as arrays read
// one cycle after the address. Expected neuron outputs come from a plain
// dot-product-plus-bias model with saturation; expected pulse timing comes
// from the frame schedule (first result at cycle IN_LEN+3, one result every
// IN_LEN+2 cycles).
// ---------------------------------------------------------------------------
module tb_flatten_fc_controller;

  localparam int IN_LEN  = 225;
  localparam int NUM_OUT = 10;
  localparam int PERIOD  = IN_LEN + 2;
  localparam int FRAME   = NUM_OUT * PERIOD;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               full = 1'b0;
  logic [7:0]         vec_idx;
  logic signed [21:0] vec_q = '0;
  logic [11:0]        waddr;
  logic signed [7:0]  w_q = '0;
  logic [3:0]         baddr;
  logic signed [31:0] b_q = '0;
  logic               res_valid;
  logic signed [31:0] result;
  logic [3:0]         neuron_idx;
  logic               busy;
  logic               done;
  logic               buf_clear;

  logic signed [21:0] vrom [0:255];
  logic signed [7:0]  wrom [0:4095];
  logic signed [31:0] brom [0:15];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  flatten_fc_controller dut (
    .clk            (clk),
    .rst            (rst),
    .i_buffer_full  (full),
    .o_vec_idx      (vec_idx),
    .i_vec_data     (vec_q),
    .o_weight_addr  (waddr),
    .i_weight       (w_q),
    .o_bias_addr    (baddr),
    .i_bias         (b_q),
    .o_result_valid (res_valid),
    .o_result       (result),
    .o_neuron_idx   (neuron_idx),
    .o_busy         (busy),
    .o_done         (done),
    .o_buffer_clear (buf_clear)
  );

  always #5 clk = ~clk;

  // Cycle counter and synchronous memory models.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    vec_q <= vrom[vec_idx];
    w_q   <= wrom[waddr];
    b_q   <= brom[baddr];
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: dot product of the vector with the neuron's weight row, plus bias, clamped to 32 bits.
  function automatic longint model(input int n);
    longint s;
    s = longint'(brom[n]);
    for (int i = 0; i < IN_LEN; i++) begin
      s += longint'(vrom[i]) * longint'(wrom[n * IN_LEN + i]);
    end
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vec_idx"}, vec_idx, 0);
    check({tag, "_waddr"},   waddr, 0);
    check({tag, "_baddr"},   baddr, 0);
    check({tag, "_result"},  result, 0);
    check({tag, "_nidx"},    neuron_idx, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_pulses"},  {res_valid, done, buf_clear}, 0);
  endtask

  // Runs one frame; abort_rel>0 asserts reset at that relative cycle instead of completing.
  task automatic run_frame(input string tag, input int abort_rel, input bit hold_full);
    int  addr_bad = 0;
    int  tim_bad  = 0;
    int  nres     = 0;
    int  pulses   = 0;
    int  t0;
    bit  aborted  = 1'b0;
    @(negedge clk);
    full = 1'b1;
    t0   = cyc;
    for (int r = 1; r <= FRAME + 3; r++) begin
      int  n, k;
      bit  exp_valid, exp_done, exp_busy;
      @(negedge clk);
      if (cyc != t0 + r) addr_bad++;
      if (!hold_full) full = 1'b0;
      if (r == abort_rel) begin
        aborted = 1'b1;
        break;
      end
      n = (r - 1) / PERIOD;
      k = (r - 1) % PERIOD;
      if (n < NUM_OUT && k < IN_LEN) begin
        if (vec_idx != k || waddr != n * IN_LEN + k || baddr != n) addr_bad++;
      end
      exp_valid = (r > 1) && (k == 0) && (n >= 1) && (n <= NUM_OUT);
      exp_done  = (r == FRAME + 1);
      exp_busy  = (r <= FRAME + 1);
      if (res_valid != exp_valid || done != exp_done ||
          buf_clear != exp_done || busy != exp_busy) tim_bad++;
      if (res_valid) begin
        check({tag, "_result"}, result, model(nres));
        check({tag, "_neuron"}, neuron_idx, nres);
        nres++;
      end
      if (buf_clear) full = 1'b0;
    end

    if (aborted) begin
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs({tag, "_after_rst"});
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (res_valid || done || buf_clear || busy) pulses++;
      end
      check({tag, "_quiet_after_rst"}, pulses, 0);
      check({tag, "_results_before_rst"}, nres, 3);
    end else begin
      check({tag, "_addr_sweep_errs"}, addr_bad, 0);
      check({tag, "_timing_errs"}, tim_bad, 0);
      check({tag, "_num_results"}, nres, NUM_OUT);
      check({tag, "_last_waddr"}, waddr, IN_LEN * NUM_OUT - 1);
      check({tag, "_last_vec_idx"}, vec_idx, IN_LEN - 1);
    end
  endtask

  task automatic fill_random;
    for (int i = 0; i < 256; i++) vrom[i] = 22'($urandom);
    for (int i = 0; i < 4096; i++) wrom[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) brom[i] = $signed(32'($urandom)) >>> 3;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) vrom[i] = '0;
    for (int i = 0; i < 4096; i++) wrom[i] = '0;
    for (int i = 0; i < 16; i++) brom[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle_no_full");

    // Ramp vector idx-100, unit weights, zero bias: every neuron yields 2700.
    for (int i = 0; i < 256; i++) vrom[i] = 22'(i - 100);
    for (int i = 0; i < 4096; i++) wrom[i] = 8'sd1;
    run_frame("ramp", 0, 1'b0);
    check("ramp_value", result, 2700);

    // Positive saturation.
    for (int i = 0; i < 256; i++) vrom[i] = 22'sd2097151;
    for (int i = 0; i < 4096; i++) wrom[i] = 8'sd127;
    for (int i = 0; i < 16; i++) brom[i] = 32'sd2147483647;
    run_frame("sat_pos", 0, 1'b0);
    check("sat_pos_value", result, 64'sd2147483647);

    // Negative saturation.
    for (int i = 0; i < 256; i++) vrom[i] = -22'sd2097152;
    for (int i = 0; i < 16; i++) brom[i] = -32'sd2147483648;
    run_frame("sat_neg", 0, 1'b0);
    check("sat_neg_value", result, -64'sd2147483648);

    // Random data, reset during RUN of neuron 3, then a full clean frame.
    fill_random();
    run_frame("abort", 3 * PERIOD + 50, 1'b0);
    run_frame("restart", 0, 1'b0);

    // Full held high until the clear pulse: exactly one frame.
    fill_random();
    run_frame("hold", 0, 1'b1);
    repeat (20) @(negedge clk);
    check("hold_stays_idle", busy, 0);

    // Index sweep: element value equals its index, random weights and biases.
    fill_random();
    for (int i = 0; i < 256; i++) vrom[i] = 22'(i);
    run_frame("sweep", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
